pipe_stage_reg: RTL

Parametrised pipeline stage register: the generalised successor of the fixed-field inter-stage latches between IF/ID/EX/MEM/WB. It carries an arbitrary-width control vector and datapath payload with a valid/ready handshake. An optional two-entry skid buffer gives full throughput with a registered `in_ready`. It also provides a synchronous pipeline flush that turns in-flight entries into bubbles, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 81 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry, flush and stall counter
//   Clk, Clrn               clock, async active-low reset
//   in_valid/in_ready       upstream handshake; in_ctrl/in_data carry the entry
//   out_valid/out_ready     downstream handshake; out_ctrl is 0 on bubbles, out_data holds when empty
//   flush                   kills held entries and the entry offered this cycle
//   occupancy, stall_cnt    entries held (0..2), saturating count of output stall cycles
module pipe_stage_reg #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 128,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);
    logic               mainValid, skidValid;
    logic [CTRL_W-1:0]  mainCtrl, skidCtrl;
    logic [DATA_W-1:0]  mainData, skidData;
    logic [STALL_W-1:0] stallCnt;
    logic               inFire, outFire;

    // With a skid entry, ready is purely a register output (skid slot free);
    // without one, the single entry may be replaced in the cycle it leaves.
    assign in_ready  = (SKID != 0) ? !skidValid : (!mainValid || out_ready);
    assign inFire    = in_valid && in_ready;
    assign outFire   = mainValid && out_ready;
    assign out_valid = mainValid;
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;
    // skidValid implies mainValid, so this encodes 0/1/2 held entries
    assign occupancy = {skidValid, mainValid && !skidValid};
    assign stall_cnt = stallCnt;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
            stallCnt  <= '0;
        end else begin
            if (flush) begin
                mainValid <= 1'b0;
                mainCtrl  <= '0;
                skidValid <= 1'b0;
                skidCtrl  <= '0;
            end else if (skidValid && outFire) begin
                mainCtrl  <= skidCtrl;
                mainData  <= skidData;
                skidValid <= 1'b0;
                skidCtrl  <= '0;
            end else if (inFire && (!mainValid || outFire)) begin
                mainValid <= 1'b1;
                mainCtrl  <= in_ctrl;
                mainData  <= in_data;
            end else if (inFire && SKID != 0) begin
                skidValid <= 1'b1;
                skidCtrl  <= in_ctrl;
                skidData  <= in_data;
            end else if (outFire) begin
                mainValid <= 1'b0;
                mainCtrl  <= '0;
            end
            if (mainValid && !out_ready && !(&stallCnt))
                stallCnt <= stallCnt + STALL_W'(1);
        end
    end
endmodule
